sad_result_tx: RTL

Result transmitter for the pipelined SAD datapath. Watches the fetch PC to detect program completion, which is a jump-to-self halt loop. On completion it snapshots v0, v1 and the current minimum SAD, then streams them out as a checksummed byte frame over a valid/ready byte interface. It sits beside `top_level`, taps the same signals the bench observes, and is the hardware-side producer of the result stream that a host or UART consumer reads.

---
 rtl/sad_result_tx_pkg.sv | 37 +++
 rtl/sad_result_tx_if.sv | 20 ++
 rtl/sad_result_tx_pc_stall_detector.sv | 47 ++++
 rtl/sad_result_tx.sv | 112 +++++++++++
 4 files changed

// File: rtl/sad_result_tx_pkg.sv
// Shared types and constants for the SAD result transmitter: FSM states,
// frame geometry and the packed snapshot of the three result words.
package sad_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } tx_state_e;

    localparam int         FRAME_LEN      = 14;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
    localparam int         IDX_W          = 4;

    typedef logic [IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

    typedef struct packed {
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] min_sad;
    } snapshot_t;

    // sel 0 picks the most significant byte so frames go out MSB first.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sad_result_tx_if.sv
// Byte stream valid/ready link between the result transmitter and its consumer.
interface sad_result_tx_if;

    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;

    modport master (
        output TxData,
        output TxValid,
        input  TxReady
    );

    modport slave (
        input  TxData,
        input  TxValid,
        output TxReady
    );

endinterface

// File: rtl/sad_result_tx_pc_stall_detector.sv
// Detects the jump-to-self halt loop: PC must repeat for STABLE_CYCLES
// consecutive compares before a single-cycle halt pulse is raised.
module pc_stall_detector #(
    parameter int STABLE_CYCLES = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PC,
    input  logic        enable,
    output logic        halt,
    output logic        pc_changed
);

    localparam int                 CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [31:0]      prev_pc_q;
    logic             prev_valid_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             pc_same;

    // The run length is held at zero whenever detection is disabled, so
    // leaving DONE always restarts the count from scratch.
    always_comb begin
        pc_same    = prev_valid_q && (PC == prev_pc_q);
        pc_changed = prev_valid_q && (PC != prev_pc_q);
        count_d    = '0;
        if (enable && pc_same) begin
            count_d = (count_q == CNT_MAX) ? CNT_MAX : count_q + 1'b1;
        end
        halt = enable && pc_same && (count_q == CNT_MAX - 1'b1);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            count_q      <= '0;
        end else begin
            prev_pc_q    <= PC;
            prev_valid_q <= 1'b1;
            count_q      <= count_d;
        end
    end

endmodule

// File: rtl/sad_result_tx.sv
// Result transmitter: on datapath halt, snapshots v0/v1/min SAD and streams a
// 14-byte checksummed frame over a zero-bubble valid/ready byte link.
module sad_result_tx
    import sad_tx_pkg::*;
#(
    parameter int         STABLE_CYCLES = 8,
    parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [31:0]            PC,
    input  logic [31:0]            V0,
    input  logic [31:0]            V1,
    input  logic [31:0]            MinSAD,
    sad_result_tx_if.master        tx,
    output logic                   Done,
    output logic                   Busy
);

    tx_state_e  state_q;
    byte_idx_t  idx_q;
    snapshot_t  snap_q;
    logic [7:0] csum_q;
    logic       valid_q;
    logic       done_q;
    logic       busy_q;

    logic       halt;
    logic       pc_changed;
    logic       accept;
    logic [7:0] frame_byte;

    pc_stall_detector #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stall (
        .Clk        (Clk),
        .Rst        (Rst),
        .PC         (PC),
        .enable     (state_q == IDLE),
        .halt       (halt),
        .pc_changed (pc_changed)
    );

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            4'd0:                       frame_byte = HEADER;
            4'd1, 4'd2, 4'd3, 4'd4:     frame_byte = word_byte(snap_q.v0, 2'(idx_q - 4'd1));
            4'd5, 4'd6, 4'd7, 4'd8:     frame_byte = word_byte(snap_q.v1, 2'(idx_q - 4'd5));
            4'd9, 4'd10, 4'd11, 4'd12:  frame_byte = word_byte(snap_q.min_sad, 2'(idx_q - 4'd9));
            4'd13:                      frame_byte = csum_q;
            default:                    frame_byte = 8'h00;
        endcase
    end

    assign accept     = valid_q && tx.TxReady;
    assign tx.TxData  = valid_q ? frame_byte : 8'h00;
    assign tx.TxValid = valid_q;
    assign Done       = done_q;
    assign Busy       = busy_q;

    // Byte k+1 becomes visible on the same edge that accepts byte k, which is
    // what gives back-to-back transfers with TxReady held high.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            csum_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (halt) begin
                        snap_q  <= '{v0: V0, v1: V1, min_sad: MinSAD};
                        csum_q  <= 8'h00;
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            if (idx_q != '0) begin
                                csum_q <= csum_q ^ frame_byte;
                            end
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (pc_changed) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
